// File: rtl/run_pattern_gen_pkg.sv
// Shared definitions for the run pattern generator and the detector bench.
//   state_e            : sequencing states of the pattern generator
//   DEFAULT_DETECT_LEN : default window length of the expected-hit counter
package run_pattern_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN0 = 2'd1,
    RUN1 = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam int DEFAULT_DETECT_LEN = 4;

endpackage : run_pattern_gen_pkg

// File: rtl/run_hit_counter.sv
// Expected-hit counter: counts valid cycles on which the current bit and the
// previous DETECT_LEN-1 valid bits are all equal. Saturates at all-ones.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear      : clears history, fill count and hit count
//   valid      : bit_in is a stream bit this cycle
//   bit_in     : stream bit
//   exp_hits   : registered saturating hit count
module run_hit_counter
  import run_pattern_gen_pkg::*;
#(
  parameter int DETECT_LEN = DEFAULT_DETECT_LEN,
  parameter int HIT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             valid,
  input  logic             bit_in,
  output logic [HIT_W-1:0] exp_hits
);

  localparam int HIST_W = DETECT_LEN - 1;
  localparam int FILL_W = $clog2(DETECT_LEN);

  logic [HIST_W-1:0] hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [HIT_W-1:0]  hits_q, hits_d;
  logic              window_full;
  logic              window_equal;

  assign window_full  = (fill_q == FILL_W'(HIST_W));
  assign window_equal = bit_in ? (&hist_q) : ~(|hist_q);

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    hits_d = hits_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
      hits_d = '0;
    end else if (valid) begin
      hist_d = (hist_q << 1) | HIST_W'(bit_in);
      if (!window_full) fill_d = fill_q + FILL_W'(1);
      if (window_full && window_equal && (hits_q != '1)) hits_d = hits_q + HIT_W'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      hits_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      hits_q <= hits_d;
    end
  end

  assign exp_hits = hits_q;

endmodule : run_hit_counter

// File: rtl/run_pattern_gen.sv
// Programmable serial stimulus source: after an accepted start it emits
// num_pairs repetitions of run0_len zeros followed by run1_len ones, one bit
// per clock, and tracks the hit count a DETECT_LEN-in-a-row detector must see.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   start                        : start request, honoured in IDLE only
//   run0_len, run1_len, num_pairs: pattern configuration, captured at start
//   bit_out, bit_valid           : serial bit and its strobe
//   busy                         : pattern in progress (equals bit_valid)
//   done                         : one-cycle pulse after the last bit
//   exp_hits                     : expected detector hit count
module run_pattern_gen
  import run_pattern_gen_pkg::*;
#(
  parameter int RUN_W      = 4,
  parameter int PAIR_W     = 8,
  parameter int DETECT_LEN = DEFAULT_DETECT_LEN,
  parameter int HIT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [RUN_W-1:0]  run0_len,
  input  logic [RUN_W-1:0]  run1_len,
  input  logic [PAIR_W-1:0] num_pairs,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              busy,
  output logic              done,
  output logic [HIT_W-1:0]  exp_hits
);

  state_e            state_q, state_d;
  logic [RUN_W-1:0]  run0_q, run0_d;
  logic [RUN_W-1:0]  run1_q, run1_d;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
  logic [PAIR_W-1:0] pair_cnt_q, pair_cnt_d;
  logic              bit_out_q, bit_out_d;
  logic              bit_valid_q, bit_valid_d;
  logic              done_q, done_d;
  logic              start_accept;
  logic              pair_end;

  always_comb begin
    state_d      = state_q;
    run0_d       = run0_q;
    run1_d       = run1_q;
    run_cnt_d    = run_cnt_q;
    pair_cnt_d   = pair_cnt_q;
    start_accept = 1'b0;
    pair_end     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          run0_d       = run0_len;
          run1_d       = run1_len;
          pair_cnt_d   = num_pairs;
          if (num_pairs == '0) begin
            state_d = FIN;
          end else if (run0_len != '0) begin
            state_d   = RUN0;
            run_cnt_d = run0_len;
          end else if (run1_len != '0) begin
            state_d   = RUN1;
            run_cnt_d = run1_len;
          end else begin
            state_d = FIN;
          end
        end
      end
      // run_cnt_q counts the bits of the current phase still to be shown,
      // including the one on bit_out this cycle.
      RUN0: begin
        if (run_cnt_q == RUN_W'(1)) begin
          if (run1_q != '0) begin
            state_d   = RUN1;
            run_cnt_d = run1_q;
          end else begin
            pair_end = 1'b1;
          end
        end else begin
          run_cnt_d = run_cnt_q - RUN_W'(1);
        end
      end
      RUN1: begin
        if (run_cnt_q == RUN_W'(1)) pair_end = 1'b1;
        else                        run_cnt_d = run_cnt_q - RUN_W'(1);
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Closing a pair: either start the next one (skipping an empty 0-run) or finish.
    if (pair_end) begin
      pair_cnt_d = pair_cnt_q - PAIR_W'(1);
      if (pair_cnt_q != PAIR_W'(1)) begin
        if (run0_q != '0) begin
          state_d   = RUN0;
          run_cnt_d = run0_q;
        end else begin
          state_d   = RUN1;
          run_cnt_d = run1_q;
        end
      end else begin
        state_d = FIN;
      end
    end
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    bit_valid_d = (state_d == RUN0) || (state_d == RUN1);
    bit_out_d   = (state_d == RUN1);
    done_d      = (state_d == FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      run0_q      <= '0;
      run1_q      <= '0;
      run_cnt_q   <= '0;
      pair_cnt_q  <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      run0_q      <= run0_d;
      run1_q      <= run1_d;
      run_cnt_q   <= run_cnt_d;
      pair_cnt_q  <= pair_cnt_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      done_q      <= done_d;
    end
  end

  // The counter consumes the bit currently on the output, so the final count
  // lands on the same edge that raises done.
  run_hit_counter #(
    .DETECT_LEN (DETECT_LEN),
    .HIT_W      (HIT_W)
  ) u_hit_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_accept),
    .valid    (bit_valid_q),
    .bit_in   (bit_out_q),
    .exp_hits (exp_hits)
  );

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign busy      = bit_valid_q;
  assign done      = done_q;

endmodule : run_pattern_gen

// File: tb/tb_run_pattern_gen.sv
// Self-checking bench for run_pattern_gen: directed cases plus randomized
// configurations, compared against a stream-level reference model.
module tb_run_pattern_gen;

  localparam int RUN_W  = 4;
  localparam int PAIR_W = 8;
  localparam int DL     = 4;
  localparam int HIT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [RUN_W-1:0]  run0_len;
  logic [RUN_W-1:0]  run1_len;
  logic [PAIR_W-1:0] num_pairs;
  logic              bit_out;
  logic              bit_valid;
  logic              busy;
  logic              done;
  logic [HIT_W-1:0]  exp_hits;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  run_pattern_gen #(
    .RUN_W      (RUN_W),
    .PAIR_W     (PAIR_W),
    .DETECT_LEN (DL),
    .HIT_W      (HIT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .run0_len  (run0_len),
    .run1_len  (run1_len),
    .num_pairs (num_pairs),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .busy      (busy),
    .done      (done),
    .exp_hits  (exp_hits)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " bit_valid"}, 32'(bit_valid), 0);
    check({tag, " busy"},      32'(busy),      0);
    check({tag, " bit_out"},   32'(bit_out),   0);
    check({tag, " done"},      32'(done),      0);
  endtask

  // Hits: every position whose DL-bit window (ending there) is all one value.
  function automatic int model_hits(input bit bits[$]);
    int hits;
    bit same;
    hits = 0;
    for (int i = DL - 1; i < bits.size(); i++) begin
      same = 1'b1;
      for (int k = 1; k < DL; k++)
        if (bits[i-k] != bits[i]) same = 1'b0;
      if (same) hits++;
    end
    return hits;
  endfunction

  task automatic scramble_config();
    run0_len  = RUN_W'($urandom_range(15, 0));
    run1_len  = RUN_W'($urandom_range(15, 0));
    num_pairs = PAIR_W'($urandom_range(255, 0));
  endtask

  // Starts one pattern from an IDLE cycle and checks it to the IDLE cycle after done.
  // mid_start_at >= 0 pulses start (with new config) while that bit is shown.
  task automatic run_pattern(input int r0, input int r1, input int np,
                             input bit hold, input int mid_start_at, input string name);
    bit exp_bits[$];
    int hits;
    for (int p = 0; p < np; p++) begin
      for (int k = 0; k < r0; k++) exp_bits.push_back(1'b0);
      for (int k = 0; k < r1; k++) exp_bits.push_back(1'b1);
    end
    hits = model_hits(exp_bits);

    run0_len  = RUN_W'(r0);
    run1_len  = RUN_W'(r1);
    num_pairs = PAIR_W'(np);
    start     = 1'b1;
    tick();
    start = hold;
    scramble_config();

    for (int i = 0; i < exp_bits.size(); i++) begin
      check($sformatf("%s bit%0d valid", name, i), 32'(bit_valid), 1);
      check($sformatf("%s bit%0d busy", name, i),  32'(busy),      1);
      check($sformatf("%s bit%0d value", name, i), 32'(bit_out),   32'(exp_bits[i]));
      check($sformatf("%s bit%0d done", name, i),  32'(done),      0);
      if (i == mid_start_at) begin
        start = 1'b1;
        scramble_config();
      end
      tick();
      if (i == mid_start_at) start = hold;
    end

    check({name, " done pulse"},    32'(done),      1);
    check({name, " done valid"},    32'(bit_valid), 0);
    check({name, " done busy"},     32'(busy),      0);
    check({name, " done bit_out"},  32'(bit_out),   0);
    check({name, " exp_hits"},      32'(exp_hits),  hits);
    tick();
    check_quiet({name, " idle"});
    check({name, " exp_hits hold"}, 32'(exp_hits),  hits);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    run0_len  = '0;
    run1_len  = '0;
    num_pairs = '0;
    repeat (3) tick();
    check_quiet("reset");
    check("reset exp_hits", 32'(exp_hits), 0);
    rst = 1'b0;
    tick();
    check_quiet("after reset");

    // Directed cases
    run_pattern(5, 5, 2, 1'b0, -1, "r5_5_p2");
    run_pattern(4, 1, 3, 1'b0, -1, "r4_1_p3");
    run_pattern(3, 3, 4, 1'b0, -1, "r3_3_p4");
    run_pattern(0, 6, 2, 1'b0, -1, "r0_6_p2");
    run_pattern(6, 0, 2, 1'b0, -1, "r6_0_p2");
    run_pattern(5, 5, 0, 1'b0, -1, "p0");
    run_pattern(0, 0, 3, 1'b0, -1, "r0_0_p3");
    run_pattern(15, 15, 1, 1'b0, -1, "r15_15_p1");
    run_pattern(5, 5, 2, 1'b0, 3, "mid_start");

    // Reset while the 7th bit of a 20-bit pattern is on the output
    run0_len  = RUN_W'(5);
    run1_len  = RUN_W'(5);
    num_pairs = PAIR_W'(2);
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("abort pre bit_valid", 32'(bit_valid), 1);
    check("abort pre bit_out",   32'(bit_out),   1);
    rst = 1'b1;
    tick();
    check_quiet("abort reset");
    check("abort exp_hits", 32'(exp_hits), 0);
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      check($sformatf("abort tail%0d done", i),  32'(done),      0);
      check($sformatf("abort tail%0d valid", i), 32'(bit_valid), 0);
    end

    // start held high: back-to-back patterns with one IDLE cycle between
    for (int n = 0; n < 3; n++)
      run_pattern(1, 1, 1, 1'b1, -1, $sformatf("held%0d", n));
    start = 1'b0;
    tick();
    check_quiet("held release");

    // Randomized configurations
    for (int n = 0; n < 25; n++) begin
      int r0;
      int r1;
      int np;
      int ms;
      r0 = int'($urandom_range(15, 0));
      r1 = int'($urandom_range(15, 0));
      np = int'($urandom_range(12, 0));
      ms = ($urandom_range(3, 0) == 0) ? int'($urandom_range(20, 0)) : -1;
      run_pattern(r0, r1, np, 1'b0, ms, $sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_run_pattern_gen
